instr_fetch_mem: RTL and testbench

Parametrised, synthesizable byte-addressed instruction memory with a registered one-word fetch buffer, multi-cycle read latency and a BUSYWAIT stall handshake toward the CPU fetch stage. It replaces the zero-state behavioural instruction array with timed fetch. It sits between the CPU PC and the instruction decoder and is loaded through a byte-wide program-load port. An optional sequential prefetch buffer hides latency for straight-line code.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_line_buffer.sv | 41 ++++
 rtl/instr_fetch_mem.sv | 215 +++++++++++++++++++++
 tb/tb_instr_fetch_mem.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// imem_pkg: FSM encoding and word-geometry helpers shared by instr_fetch_mem. Rev 1.0
package imem_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } imem_state_e;

  localparam int DEFAULT_WORD_BYTES = 4;
  localparam int OFFSET_W           = $clog2(DEFAULT_WORD_BYTES);

  function automatic int offset_width(input int word_bytes);
    return $clog2(word_bytes);
  endfunction

  function automatic int instr_width(input int word_bytes);
    return 8 * word_bytes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_line_buffer.sv
`default_nettype none
// imem_line_buffer: one tagged instruction word with lookup compare, fill, clear and write-invalidate. Rev 1.0
module imem_line_buffer #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              clr,
  input  logic              inval,
  input  logic [TAG_W-1:0]  inval_tag,
  output logic              hit,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);

  logic valid;

  assign hit = valid && (tag == lookup_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      tag   <= fill_tag;
      data  <= fill_data;
      // a write landing on the word being filled leaves the captured copy stale
      valid <= !(inval && (inval_tag == fill_tag));
    end else if (clr || (inval && (inval_tag == tag))) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// instr_fetch_mem: byte-loaded instruction memory with registered fetch buffer and BUSYWAIT stall. Rev 1.0
// Define IMEM_PREFETCH_EN to add a sequential next-word prefetch buffer.
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int WORD_BYTES   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 READ,
  input  logic [31:0]                          ADDRESS,
  output logic [instr_width(WORD_BYTES)-1:0]   INSTRUCTION,
  output logic                                 BUSYWAIT,
  output logic                                 MISALIGN,
  input  logic                                 LOAD_EN,
  input  logic [ADDR_W-1:0]                    LOAD_ADDR,
  input  logic [7:0]                           LOAD_DATA
);

  localparam int OFS_W   = offset_width(WORD_BYTES);
  localparam int IDX_W   = ADDR_W - OFS_W;
  localparam int INSTR_W = instr_width(WORD_BYTES);
  localparam int CNT_W   = $clog2(READ_LATENCY + 1);
  // the request cycle in IDLE already counts toward the latency
  localparam logic [CNT_W-1:0] FETCH_CNT0 = CNT_W'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
  end

  function automatic logic [INSTR_W-1:0] word_at(input logic [IDX_W-1:0] idx);
    logic [INSTR_W-1:0] w;
    for (int k = 0; k < WORD_BYTES; k++) begin
      w[8*k +: 8] = mem[ADDR_W'(int'(idx) * WORD_BYTES + k)];
    end
    return w;
  endfunction

  logic [IDX_W-1:0]   idx_in, load_idx, fetch_idx, fetch_idx_nx, fill_idx, main_tag;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [INSTR_W-1:0] fill_data;
  logic               main_hit, req_miss, fill, busy, demand;
  logic               unused_addr_hi;
  imem_state_e        state, state_nx;

  assign idx_in         = ADDRESS[ADDR_W-1:OFS_W];
  assign load_idx       = LOAD_ADDR[ADDR_W-1:OFS_W];
  assign unused_addr_hi = ^ADDRESS[31:ADDR_W];
  assign req_miss       = READ && !main_hit;
  assign MISALIGN       = READ && ((ADDRESS & 32'(WORD_BYTES - 1)) != 32'd0);
  assign BUSYWAIT       = RESET && busy;

`ifdef IMEM_PREFETCH_EN
  logic               pf_hit, pf_busy, pf_pending, pf_start, pf_abort, pf_to_main, pf_clr, pf_done, pf_fill;
  logic [IDX_W-1:0]   pf_idx, pf_start_idx, pf_tag_unused;
  logic [CNT_W-1:0]   pf_cnt;
  logic [INSTR_W-1:0] pf_data, pf_fill_data;

  assign pf_done      = pf_busy && (pf_cnt == '0);
  assign pf_fill      = pf_done && !pf_abort && !pf_to_main;
  assign pf_fill_data = word_at(pf_idx);
  assign fill_data    = pf_clr ? pf_data : word_at(fill_idx);
`else
  logic unused_main_tag;
  assign unused_main_tag = ^main_tag;
  assign fill_data       = word_at(fill_idx);
`endif

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    fetch_idx_nx = fetch_idx;
    fill         = 1'b0;
    fill_idx     = fetch_idx;
    busy         = 1'b0;
    demand       = 1'b0;
`ifdef IMEM_PREFETCH_EN
    pf_start     = 1'b0;
    pf_start_idx = main_tag + 1'b1;
    pf_abort     = 1'b0;
    pf_to_main   = 1'b0;
    pf_clr       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (req_miss) begin
          busy = 1'b1;
`ifdef IMEM_PREFETCH_EN
          if (pf_hit) begin
            fill         = 1'b1;
            fill_idx     = idx_in;
            pf_clr       = 1'b1;
            pf_start     = 1'b1;
            pf_start_idx = idx_in + 1'b1;
          end else if (pf_busy && (pf_idx == idx_in)) begin
            if (pf_done) begin
              fill       = 1'b1;
              fill_idx   = pf_idx;
              pf_to_main = 1'b1;
            end
          end else begin
            pf_abort = 1'b1;
            demand   = 1'b1;
          end
`else
          demand = 1'b1;
`endif
          if (demand) begin
            if (READ_LATENCY == 1) begin
              fill     = 1'b1;
              fill_idx = idx_in;
            end else begin
              state_nx     = S_FETCH;
              cnt_nx       = FETCH_CNT0;
              fetch_idx_nx = idx_in;
            end
          end
        end
`ifdef IMEM_PREFETCH_EN
        else if (pf_pending) begin
          pf_start = 1'b1;
        end
`endif
      end
      S_FETCH: begin
        busy = 1'b1;
        if (cnt == '0) begin
          fill     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      fetch_idx <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      fetch_idx <= fetch_idx_nx;
    end
  end

  imem_line_buffer #(
    .TAG_W  (IDX_W),
    .DATA_W (INSTR_W)
  ) u_main_buf (
    .clk        (CLK),
    .rst_n      (RESET),
    .lookup_tag (idx_in),
    .fill       (fill),
    .fill_tag   (fill_idx),
    .fill_data  (fill_data),
    .clr        (1'b0),
    .inval      (LOAD_EN),
    .inval_tag  (load_idx),
    .hit        (main_hit),
    .tag        (main_tag),
    .data       (INSTRUCTION)
  );

`ifdef IMEM_PREFETCH_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pf_busy    <= 1'b0;
      pf_pending <= 1'b0;
      pf_idx     <= '0;
      pf_cnt     <= '0;
    end else begin
      if (pf_start) begin
        pf_busy <= 1'b1;
        pf_idx  <= pf_start_idx;
        pf_cnt  <= CNT_W'(READ_LATENCY - 1);
      end else if (pf_abort || pf_done) begin
        pf_busy <= 1'b0;
      end else if (pf_busy) begin
        pf_cnt <= pf_cnt - 1'b1;
      end
      if (pf_start) pf_pending <= 1'b0;
      else if (fill) pf_pending <= 1'b1;
    end
  end

  imem_line_buffer #(
    .TAG_W  (IDX_W),
    .DATA_W (INSTR_W)
  ) u_pf_buf (
    .clk        (CLK),
    .rst_n      (RESET),
    .lookup_tag (idx_in),
    .fill       (pf_fill),
    .fill_tag   (pf_idx),
    .fill_data  (pf_fill_data),
    .clr        (pf_clr),
    .inval      (LOAD_EN),
    .inval_tag  (load_idx),
    .hit        (pf_hit),
    .tag        (pf_tag_unused),
    .data       (pf_data)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// tb_instr_fetch_mem: directed vector table plus hand-written multi-cycle sequences for instr_fetch_mem.
module tb_instr_fetch_mem;

  localparam int ADDR_W = 10;
`ifdef IMEM_PREFETCH_EN
  localparam int SEQ_STALL = 1;
`else
  localparam int SEQ_STALL = 2;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              rd        = 1'b0;
  logic              load_en   = 1'b0;
  logic [31:0]       address   = '0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [7:0]        load_data = '0;
  logic [31:0]       instruction;
  logic              busywait;
  logic              misalign;

  int tests = 0;
  int fails = 0;

  instr_fetch_mem #(
    .ADDR_W       (ADDR_W),
    .WORD_BYTES   (4),
    .READ_LATENCY (2)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .READ        (rd),
    .ADDRESS     (address),
    .INSTRUCTION (instruction),
    .BUSYWAIT    (busywait),
    .MISALIGN    (misalign),
    .LOAD_EN     (load_en),
    .LOAD_ADDR   (load_addr),
    .LOAD_DATA   (load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    logic        mis;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en   = 1'b0;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) load_byte(a + ADDR_W'(b), w[8*b +: 8]);
  endtask

  // counts BUSYWAIT-high cycles from the current cycle until it falls
  task automatic wait_ready(output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!busywait) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL busywait_timeout: still high after 20 cycles, expected low");
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output int stalls, output logic mis);
    @(posedge clk); #1;
    rd      = 1'b1;
    address = a;
    #1;
    mis = misalign;
    wait_ready(stalls);
    data = instruction;
    @(posedge clk); #1;
    rd = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          s;
    logic        m;

    vecs[0] = '{32'h0000_0000, 32'h0000_0005, 2,         1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0005, 0,         1'b0};
    vecs[2] = '{32'h0000_0004, 32'h4433_2211, SEQ_STALL, 1'b0};
    vecs[3] = '{32'h0000_0008, 32'h8877_6655, SEQ_STALL, 1'b0};
    vecs[4] = '{32'h0000_0003, 32'h0000_0005, 2,         1'b1};
    vecs[5] = '{32'h0000_0400, 32'h0000_0005, 0,         1'b0};
    vecs[6] = '{32'h0000_0014, 32'h0123_4567, 2,         1'b0};
    vecs[7] = '{32'h0000_000C, 32'hCCBB_AA99, 2,         1'b0};

    // program load while held in reset, with a read request pending
    rd      = 1'b1;
    address = 32'h0;
    load_word(10'h000, 32'h0000_0005);
    load_word(10'h004, 32'h4433_2211);
    load_word(10'h008, 32'h8877_6655);
    load_word(10'h00C, 32'hCCBB_AA99);
    load_word(10'h010, 32'hDEAD_BEEF);
    load_word(10'h014, 32'h0123_4567);
    load_word(10'h020, 32'hCAFE_F00D);
    @(negedge clk);
    check("reset_busywait", {31'd0, busywait}, 32'd0);
    check("reset_instruction", instruction, 32'd0);
    @(posedge clk); #1;
    rd    = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].addr, d, s, m);
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      if (vecs[i].stall >= 0) check($sformatf("vec%0d_stall", i), 32'(s), 32'(vecs[i].stall));
      check($sformatf("vec%0d_misalign", i), {31'd0, m}, {31'd0, vecs[i].mis});
    end

    // load-port write into a buffered word forces a refetch
    do_read(32'h4, d, s, m);
    check("inval_before_data", d, 32'h4433_2211);
    load_byte(10'd6, 8'hAA);
    do_read(32'h4, d, s, m);
    check("inval_after_stall", 32'(s), 32'd2);
    check("inval_after_data", d, 32'h44AA_2211);

    // address switch while a fetch is in flight
    @(posedge clk); #1;
    rd      = 1'b1;
    address = 32'h10;
    @(negedge clk);
    check("midfetch_req_busy", {31'd0, busywait}, 32'd1);
    @(posedge clk); #1;
    address = 32'h20;
    @(negedge clk);
    check("midfetch_fetch_busy", {31'd0, busywait}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("midfetch_first_word", instruction, 32'hDEAD_BEEF);
    check("midfetch_rereq_busy", {31'd0, busywait}, 32'd1);
    @(posedge clk); #1;
    wait_ready(s);
    check("midfetch_extra_stall", 32'(s), 32'd1);
    check("midfetch_second_word", instruction, 32'hCAFE_F00D);
    @(posedge clk); #1;
    rd = 1'b0;
    repeat (3) @(posedge clk);

    // reset asserted in the FETCH cycle of a miss
    @(posedge clk); #1;
    rd      = 1'b1;
    address = 32'h14;
    @(negedge clk);
    check("rstfetch_req_busy", {31'd0, busywait}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstfetch_busywait", {31'd0, busywait}, 32'd0);
    check("rstfetch_instruction", instruction, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(s);
    check("rstfetch_refetch_stall", 32'(s), 32'd2);
    check("rstfetch_refetch_data", instruction, 32'h0123_4567);
    @(posedge clk); #1;
    rd = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
